cntr_updn_n: RTL and testbench



---
 rtl/cntr_pkg.sv | 43 ++++
 rtl/cntr_updn_nxt.sv | 73 +++++++
 rtl/cntr_updn_n.sv | 77 +++++++
 tb/tb_cntr_updn_n.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cntr_pkg.sv
// ============================================================================
// Module   : cntr_pkg
// Brief    : Shared state encoding and next-state priority helper for the
//            parametrised loadable up/down counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cntr_pkg;

  localparam int STATE_W = 3;

  // Operation applied at the most recent clock edge
  localparam logic [STATE_W-1:0] ST_IDLE = 3'b000;
  localparam logic [STATE_W-1:0] ST_CLR  = 3'b001;
  localparam logic [STATE_W-1:0] ST_LOAD = 3'b010;
  localparam logic [STATE_W-1:0] ST_INC  = 3'b011;
  localparam logic [STATE_W-1:0] ST_DEC  = 3'b100;

  // Request priority: clear beats load, load beats counting, counting needs en
  function automatic logic [STATE_W-1:0] sel_state(
    input logic clr,
    input logic load,
    input logic en,
    input logic inc
  );
    logic [STATE_W-1:0] w_st;
    if (clr)
      w_st = ST_CLR;
    else if (load)
      w_st = ST_LOAD;
    else if (en && inc)
      w_st = ST_INC;
    else if (en)
      w_st = ST_DEC;
    else
      w_st = ST_IDLE;
    return w_st;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cntr_updn_nxt.sv
// ============================================================================
// Module   : cntr_updn_nxt
// Brief    : Combinational next-count / terminal-count / zero function of the
//            selected operation, the current count and the load value.
//            Optional macro CNTR_UPDN_SAT_EN: saturate at the range ends
//            instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cntr_updn_nxt
  import cntr_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic [STATE_W-1:0] i_state,
  input  logic [WIDTH-1:0]   i_count,
  input  logic [WIDTH-1:0]   i_d_in,
  output logic [WIDTH-1:0]   o_count_nxt,
  output logic               o_tc_nxt,
  output logic               o_zero_nxt
);

  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_zero = '0;

  logic w_at_max;
  logic w_at_zero;

  assign w_at_max  = (i_count == MAX_VAL);
  assign w_at_zero = (i_count == c_zero);

  // Next count and wrap/boundary pulse; unknown state codes behave as a hold
  always_comb begin
    o_count_nxt = i_count;
    o_tc_nxt    = 1'b0;
    case (i_state)
      ST_CLR: begin
        o_count_nxt = c_zero;
      end
      ST_LOAD: begin
        // Out-of-range loads clamp so the count never leaves 0..MAX_VAL
        o_count_nxt = (i_d_in > MAX_VAL) ? MAX_VAL : i_d_in;
      end
      ST_INC: begin
        o_tc_nxt = w_at_max;
`ifdef CNTR_UPDN_SAT_EN
        o_count_nxt = w_at_max ? MAX_VAL : (i_count + c_one);
`else
        o_count_nxt = w_at_max ? c_zero : (i_count + c_one);
`endif
      end
      ST_DEC: begin
        o_tc_nxt = w_at_zero;
`ifdef CNTR_UPDN_SAT_EN
        o_count_nxt = w_at_zero ? c_zero : (i_count - c_one);
`else
        o_count_nxt = w_at_zero ? MAX_VAL : (i_count - c_one);
`endif
      end
      default: begin
        o_count_nxt = i_count;
        o_tc_nxt    = 1'b0;
      end
    endcase
  end

  assign o_zero_nxt = (o_count_nxt == c_zero);

endmodule

`default_nettype wire

// File: rtl/cntr_updn_n.sv
// ============================================================================
// Module   : cntr_updn_n
// Brief    : Parametrised loadable up/down counter with count enable,
//            synchronous clear, clamped load, modulus MAX_VAL, registered
//            terminal-count pulse and zero flag.
//            Optional macro CNTR_UPDN_SAT_EN: saturating instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cntr_updn_n
  import cntr_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               clr,
  input  logic               load,
  input  logic               inc,
  input  logic [WIDTH-1:0]   d_in,
  output logic [WIDTH-1:0]   d_out,
  output logic               tc,
  output logic               zero,
  output logic [STATE_W-1:0] o_state
);

  logic [STATE_W-1:0] r_state;
  logic [WIDTH-1:0]   r_count;
  logic               r_tc;
  logic               r_zero;

  logic [STATE_W-1:0] w_state_nxt;
  logic [WIDTH-1:0]   w_count_nxt;
  logic               w_tc_nxt;
  logic               w_zero_nxt;

  // The operation is chosen from this edge's inputs, so count and state move together
  assign w_state_nxt = sel_state(clr, load, en, inc);

  cntr_updn_nxt #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_nxt (
    .i_state     (w_state_nxt),
    .i_count     (r_count),
    .i_d_in      (d_in),
    .o_count_nxt (w_count_nxt),
    .o_tc_nxt    (w_tc_nxt),
    .o_zero_nxt  (w_zero_nxt)
  );

  // State, count and flags registered together; reset clears them immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_tc    <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
      r_zero  <= w_zero_nxt;
    end
  end

  assign d_out   = r_count;
  assign tc      = r_tc;
  assign zero    = r_zero;
  assign o_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_cntr_updn_n.sv
// ============================================================================
// Module   : tb_cntr_updn_n
// Brief    : Bench for cntr_updn_n; runs a default 8-bit counter and a 4-bit
//            decade counter (MAX_VAL=9) side by side against a modular
//            arithmetic reference. Honours CNTR_UPDN_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cntr_updn_n;

  localparam int M8 = 255;
  localparam int M4 = 9;

  logic       clk;
  logic       reset_n;
  logic       en, clr, load, inc;
  logic [7:0] d_in8, d_out8;
  logic [3:0] d_in4, d_out4;
  logic       tc8, zero8, tc4, zero4;
  logic [2:0] st8, st4;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: expected count, tc and operation code for each counter
  int e8, e4, eop;
  bit t8, t4;

  cntr_updn_n u_dut8 (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load), .inc(inc),
    .d_in(d_in8), .d_out(d_out8), .tc(tc8), .zero(zero8), .o_state(st8)
  );

  cntr_updn_n #(.WIDTH(4), .MAX_VAL(4'd9)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load), .inc(inc),
    .d_in(d_in4), .d_out(d_out4), .tc(tc4), .zero(zero4), .o_state(st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operation codes: 0 idle, 1 clear, 2 load, 3 up, 4 down
  function automatic int ref_op(bit c, bit l, bit e, bit i);
    if (c) return 1;
    if (l) return 2;
    if (e) return i ? 3 : 4;
    return 0;
  endfunction

  function automatic int ref_next(int op, int m, int din, int c);
    case (op)
      1: return 0;
      2: return (din > m) ? m : din;
`ifdef CNTR_UPDN_SAT_EN
      3: return (c == m) ? m : c + 1;
      4: return (c == 0) ? 0 : c - 1;
`else
      3: return (c + 1) % (m + 1);
      4: return (c + m) % (m + 1);
`endif
      default: return c;
    endcase
  endfunction

  function automatic bit ref_tc(int op, int m, int c);
    return (op == 3 && c == m) || (op == 4 && c == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".d8"},    32'(d_out8), 32'(e8));
    check({where, ".tc8"},   32'(tc8),    32'(t8));
    check({where, ".zero8"}, 32'(zero8),  32'(e8 == 0));
    check({where, ".st8"},   32'(st8),    32'(eop));
    check({where, ".d4"},    32'(d_out4), 32'(e4));
    check({where, ".tc4"},   32'(tc4),    32'(t4));
    check({where, ".zero4"}, 32'(zero4),  32'(e4 == 0));
    check({where, ".st4"},   32'(st4),    32'(eop));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check after it
  task automatic step(input string where, input bit c, input bit l, input bit e,
                      input bit i, input logic [7:0] d8, input logic [3:0] d4);
    clr = c; load = l; en = e; inc = i; d_in8 = d8; d_in4 = d4;
    @(posedge clk);
    eop = ref_op(c, l, e, i);
    t8  = ref_tc(eop, M8, e8);
    t4  = ref_tc(eop, M4, e4);
    e8  = ref_next(eop, M8, int'(d8), e8);
    e4  = ref_next(eop, M4, int'(d4), e4);
    #1;
    check_all(where);
    @(negedge clk);
  endtask

  // Assert reset between edges and check that outputs clear without an edge
  task automatic async_reset(input string where);
    #2;
    reset_n = 1'b0;
    #1;
    e8 = 0; e4 = 0; t8 = 0; t4 = 0; eop = 0;
    check_all(where);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    clr = 1'b0; load = 1'b0; en = 1'b1; inc = 1'b1;
    d_in8 = 8'h00; d_in4 = 4'h0;
    e8 = 0; e4 = 0; t8 = 0; t4 = 0; eop = 0;

    // Reset held across edges with counting requested
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;
    en = 1'b0; inc = 1'b0;

    // Reset in the middle of counting
    step("ld5a", 0, 1, 0, 0, 8'h5A, 4'd5);
    for (int k = 0; k < 3; k++) step("inc5a", 0, 0, 1, 1, 8'h00, 4'd0);
    async_reset("mid_rst");

    // 8-bit wrap through FF to 00
    step("ldfe", 0, 1, 0, 0, 8'hFE, 4'd0);
    step("incff", 0, 0, 1, 1, 8'h00, 4'd0);
    step("inc00", 0, 0, 1, 1, 8'h00, 4'd0);

    // Decade counter: wrap down from 0, then a full 0..9 cycle
    step("ld0", 0, 1, 0, 0, 8'h00, 4'd0);
    step("dec0", 0, 0, 1, 0, 8'h00, 4'd0);
    for (int k = 0; k < 10; k++) step("inc10", 0, 0, 1, 1, 8'h00, 4'd0);

    // Priority of simultaneous requests
    step("ld7", 0, 1, 0, 0, 8'd7, 4'd7);
    step("prio_clr", 1, 1, 1, 1, 8'd9, 4'd9);
    step("prio_ld", 0, 1, 1, 0, 8'd3, 4'd3);

    // Clamped load, then hold with en low
    step("ld14", 0, 1, 0, 0, 8'd14, 4'd14);
    for (int k = 0; k < 4; k++) step("hold", 0, 0, 0, 1, 8'h00, 4'd0);

    // Boundary attempts: saturate or wrap depending on the build
    step("ldff", 0, 1, 0, 0, 8'hFF, 4'd9);
    for (int k = 0; k < 3; k++) step("incmax", 0, 0, 1, 1, 8'h00, 4'd0);
    step("ld00", 0, 1, 0, 0, 8'h00, 4'd0);
    step("decmin", 0, 0, 1, 0, 8'h00, 4'd0);

    // Random traffic with occasional asynchronous resets
    for (int k = 0; k < 400; k++) begin
      step("rand",
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           8'($urandom),
           4'($urandom));
      if (k % 97 == 96) async_reset("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
